store_buffer: RTL and testbench



---
 rtl/store_buffer.sv | 108 ++++++++++
 tb/tb_store_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: MEM-stage write-back store buffer with load ordering and sync/drain; define STORE_BUF_FWD_EN to forward matching loads instead of stalling them.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   st_valid_i,
    input  logic [AW-1:0]          st_addr_i,
    input  logic [31:0]            st_data_i,
    output logic                   st_ready_o,
    input  logic                   ld_valid_i,
    input  logic [AW-1:0]          ld_addr_i,
    output logic                   ld_stall_o,
    output logic                   ld_hit_o,
    output logic [31:0]            ld_fwd_data_o,
    input  logic                   sync_req_i,
    output logic                   sync_done_o,
    output logic [AW-1:0]          mem_address_o,
    output logic [31:0]            mem_write_data_o,
    output logic                   mem_mem_write_o,
    output logic                   mem_mem_read_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t        state_q, state_d;
    logic [AW-3:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q, idx;
    logic [CW-1:0] count_q, count_d;
    logic          sync_done_q, sync_done_d;
    logic          match, push, pop, drain;
    logic          st_unused;
`ifdef STORE_BUF_FWD_EN
    logic [31:0]   match_data;
`endif
    assign st_unused   = ^st_addr_i[1:0];
    assign count_o     = count_q;
    assign sync_done_o = sync_done_q;
    // Scan oldest to youngest so the last hit is the youngest resident store.
    always_comb begin
        match = 1'b0;
        idx   = rd_ptr_q;
`ifdef STORE_BUF_FWD_EN
        match_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q && addr_q[idx] == ld_addr_i[AW-1:2]) begin
                match = 1'b1;
`ifdef STORE_BUF_FWD_EN
                match_data = data_q[idx];
`endif
            end
        end
    end
    always_comb begin
        drain            = state_q == DRAIN;
        st_ready_o       = !drain && count_q != CW'(DEPTH);
        push             = st_valid_i && st_ready_o;
        mem_mem_read_o   = ld_valid_i && !match && !(drain && count_q != '0);
        mem_mem_write_o  = count_q != '0 && !mem_mem_read_o;
        pop              = mem_mem_write_o;
        mem_address_o    = mem_mem_write_o ? {addr_q[rd_ptr_q], 2'b00} : mem_mem_read_o ? ld_addr_i : '0;
        mem_write_data_o = mem_mem_write_o ? data_q[rd_ptr_q] : '0;
`ifdef STORE_BUF_FWD_EN
        ld_hit_o         = ld_valid_i && match && !drain;
        ld_fwd_data_o    = ld_hit_o ? match_data : '0;
        ld_stall_o       = ld_valid_i && drain;
`else
        ld_hit_o         = 1'b0;
        ld_fwd_data_o    = '0;
        ld_stall_o       = ld_valid_i && (drain || match);
`endif
        count_d          = count_q + CW'(push) - CW'(pop);
        state_d          = state_q;
        sync_done_d      = 1'b0;
        if (!drain && sync_req_i)
            state_d = DRAIN;
        else if (drain && count_q == '0) begin
            state_d     = IDLE;
            sync_done_d = 1'b1;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            sync_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_q + PW'(pop);
            wr_ptr_q    <= wr_ptr_q + PW'(push);
            count_q     <= count_d;
            sync_done_q <= sync_done_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr_q] <= st_addr_i[AW-1:2];
            data_q[wr_ptr_q] <= st_data_i;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: vector table, directed corner sequences and random traffic against a queue-based model of the store buffer.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst_n, st_valid, ld_valid, sync_req;
    logic [31:0] st_addr, st_data, ld_addr;
    logic        st_ready, ld_stall, ld_hit, sync_done, mem_mem_write, mem_mem_read;
    logic [31:0] ld_fwd_data, mem_address, mem_write_data;
    logic [2:0]  count;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data), .st_ready_o(st_ready),
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_stall_o(ld_stall), .ld_hit_o(ld_hit),
        .ld_fwd_data_o(ld_fwd_data), .sync_req_i(sync_req), .sync_done_o(sync_done),
        .mem_address_o(mem_address), .mem_write_data_o(mem_write_data),
        .mem_mem_write_o(mem_mem_write), .mem_mem_read_o(mem_mem_read), .count_o(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [29:0] wa; logic [31:0] d; } ent_t;
    typedef struct {
        bit sv; logic [31:0] sa, sd; bit lv; logic [31:0] la;
        int cnt; bit rdy, wr, rd; logic [31:0] addr, wd;
    } vec_t;

    ent_t        q[$];
    bit          m_drain, m_done, tab_on, last_rd;
    vec_t        cur;
    vec_t        tab[11];
    logic [31:0] mem [256];
    logic [31:0] last_rdata;
    int          compared, mismatched;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock: drive at posedge+1, compare against the model at negedge, act as memory, advance the model.
    task automatic cyc(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                       input bit lv, input logic [31:0] la, input bit sr);
        bit hit, drn, e_rdy, e_stall, e_hit, e_wr, e_rd;
        logic [31:0] hd, e_fwd, e_addr, e_wd;
        int n;
        st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la; sync_req = sr;
        @(negedge clk);
        n = q.size(); drn = m_drain; hit = 0; hd = 0;
        foreach (q[i]) if (q[i].wa == la[31:2]) begin hit = 1; hd = q[i].d; end
        e_rdy = !drn && n < 4;
`ifdef STORE_BUF_FWD_EN
        e_hit = lv && hit && !drn; e_fwd = e_hit ? hd : 32'h0; e_stall = lv && drn;
`else
        e_hit = 0; e_fwd = 0; e_stall = lv && (drn || hit);
`endif
        e_wr = 0; e_rd = 0;
        if ((drn || (lv && hit && !e_hit)) && n != 0) e_wr = 1;
        else if (lv && !hit) e_rd = 1;
        else if (n != 0) e_wr = 1;
        e_addr = e_wr ? {q[0].wa, 2'b00} : e_rd ? la : 32'h0;
        e_wd   = e_wr ? q[0].d : 32'h0;
        chk("st_ready", st_ready, e_rdy);
        chk("ld_stall", ld_stall, e_stall);
        chk("ld_hit", ld_hit, e_hit);
        chk("ld_fwd_data", ld_fwd_data, e_fwd);
        chk("sync_done", sync_done, m_done);
        chk("mem_write", mem_mem_write, e_wr);
        chk("mem_read", mem_mem_read, e_rd);
        chk("mem_address", mem_address, e_addr);
        chk("count", count, n);
        if (e_wr) chk("mem_wdata", mem_write_data, e_wd);
        if (tab_on) begin
            chk("tab_count", count, cur.cnt);
            chk("tab_st_ready", st_ready, cur.rdy);
            chk("tab_mem_write", mem_mem_write, cur.wr);
            chk("tab_mem_read", mem_mem_read, cur.rd);
            chk("tab_mem_address", mem_address, cur.addr);
            if (cur.wr) chk("tab_mem_wdata", mem_write_data, cur.wd);
        end
        if (mem_mem_write) mem[mem_address[9:2]] = mem_write_data;
        last_rd = mem_mem_read;
        last_rdata = mem[la[9:2]];
        if (e_wr) void'(q.pop_front());
        if (sv && e_rdy) q.push_back('{sa[31:2], sd});
        m_done = 0;
        if (!drn && sr) m_drain = 1;
        else if (drn && n == 0) begin m_drain = 0; m_done = 1; end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int stalls, zc, dc;
        compared = 0; mismatched = 0; m_drain = 0; m_done = 0; tab_on = 0;
        rst_n = 0; st_valid = 0; ld_valid = 0; sync_req = 0; st_addr = 0; st_data = 0; ld_addr = 0;
        foreach (mem[i]) mem[i] = 0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_st_ready", st_ready, 1);
        chk("rst_mem_write", mem_mem_write, 0);
        chk("rst_sync_done", sync_done, 0);
        ld_valid = 1; ld_addr = 32'h44; #1;
        chk("rst_mem_read", mem_mem_read, 1);
        chk("rst_mem_addr", mem_address, 32'h44);
        ld_valid = 0;
        @(posedge clk); #1; rst_n = 1;

        // Loads to 0x100 hold the port so four stores fill the buffer.
        tab[0]  = '{1, 'h10, 'hA0, 1, 'h100, 0, 1, 0, 1, 'h100, 0};
        tab[1]  = '{1, 'h14, 'hA1, 1, 'h100, 1, 1, 0, 1, 'h100, 0};
        tab[2]  = '{1, 'h18, 'hA2, 1, 'h100, 2, 1, 0, 1, 'h100, 0};
        tab[3]  = '{1, 'h1C, 'hA3, 1, 'h100, 3, 1, 0, 1, 'h100, 0};
        tab[4]  = '{1, 'h20, 'hA4, 1, 'h100, 4, 0, 0, 1, 'h100, 0};
        tab[5]  = '{1, 'h20, 'hA4, 0, 0,     4, 0, 1, 0, 'h10, 'hA0};
        tab[6]  = '{0, 0,    0,    0, 0,     3, 1, 1, 0, 'h14, 'hA1};
        tab[7]  = '{0, 0,    0,    1, 'h40,  2, 1, 0, 1, 'h40, 0};
        tab[8]  = '{0, 0,    0,    0, 0,     2, 1, 1, 0, 'h18, 'hA2};
        tab[9]  = '{0, 0,    0,    0, 0,     1, 1, 1, 0, 'h1C, 'hA3};
        tab[10] = '{0, 0,    0,    0, 0,     0, 1, 0, 0, 0,    0};
        for (int i = 0; i < 11; i++) begin
            cur = tab[i]; tab_on = 1;
            cyc(cur.sv, cur.sa, cur.sd, cur.lv, cur.la, 0);
        end
        tab_on = 0;
        for (int i = 0; i < 4; i++) chk("fill_mem", mem[4 + i], 32'hA0 + i);

        // Asynchronous reset with three entries pending.
        cyc(1, 'h30, 'hB0, 1, 'h100, 0);
        cyc(1, 'h34, 'hB1, 1, 'h100, 0);
        cyc(1, 'h38, 'hB2, 1, 'h100, 0);
        st_valid = 0; ld_valid = 0; sync_req = 0;
        rst_n = 0; #2;
        chk("midrst_count", count, 0);
        chk("midrst_st_ready", st_ready, 1);
        chk("midrst_mem_write", mem_mem_write, 0);
        q.delete(); m_drain = 0; m_done = 0;
        @(posedge clk); #1; rst_n = 1;
        idle(4);
        chk("midrst_no_write", mem[12], 0);

        // Two stores to the same word; the younger one must win.
        cyc(1, 'h20, 'h11, 1, 'h100, 0);
        cyc(1, 'h20, 'h22, 1, 'h100, 0);
`ifdef STORE_BUF_FWD_EN
        ld_valid = 1; ld_addr = 'h20; #2;
        chk("fwd_hit", ld_hit, 1);
        chk("fwd_data", ld_fwd_data, 'h22);
        chk("fwd_stall", ld_stall, 0);
        chk("fwd_drains", mem_mem_write, 1);
        cyc(0, 0, 0, 1, 'h20, 0);
`else
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1; ld_addr = 'h20; #2;
            if (!ld_stall) break;
            stalls++;
            cyc(0, 0, 0, 1, 'h20, 0);
        end
        chk("stall_cycles", stalls, 2);
        cyc(0, 0, 0, 1, 'h20, 0);
        chk("stall_read", last_rd, 1);
        chk("stall_read_data", last_rdata, 'h22);
`endif
        idle(4);

        // Sync with stores and loads held during the drain.
        cyc(1, 'h50, 'hC0, 1, 'h100, 0);
        cyc(1, 'h54, 'hC1, 1, 'h100, 0);
        cyc(1, 'h58, 'hC2, 1, 'h100, 0);
        cyc(1, 'h5C, 'hC3, 0, 0, 1);
        zc = -1; dc = -1;
        for (int i = 0; i < 20; i++) begin
            st_valid = 1; ld_valid = 1; ld_addr = 'h60; sync_req = 0; #2;
            if (sync_done) begin dc = i; break; end
            chk("sync_st_ready", st_ready, 0);
            chk("sync_ld_stall", ld_stall, 1);
            if (count == 0 && zc < 0) zc = i;
            cyc(1, 'h5C, 'hC3, 1, 'h60, 0);
        end
        if (dc < 0) chk("sync_done_seen", 0, 1);
        else chk("sync_done_after_zero", dc - zc, 1);
        cyc(0, 0, 0, 0, 0, 0);
        idle(6);
        for (int i = 0; i < 4; i++) chk("sync_mem", mem[20 + i], 32'hC0 + i);

        // Sync on an empty buffer.
        cyc(0, 0, 0, 0, 0, 1);
        dc = -1;
        for (int i = 0; i < 5; i++) begin
            sync_req = 0; #2;
            if (sync_done) begin dc = i; break; end
            cyc(0, 0, 0, 0, 0, 0);
        end
        chk("sync_empty_latency", dc, 1);
        idle(2);

        // Push and pop in the same cycle.
        cyc(1, 'h70, 'hD0, 1, 'h100, 0);
        cyc(1, 'h74, 'hD1, 1, 'h100, 0);
        cyc(1, 'h78, 'hD2, 0, 0, 0);
        chk("overlap_count", count, 2);
        idle(4);
        for (int i = 0; i < 3; i++) chk("overlap_mem", mem[28 + i], 32'hD0 + i);

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 1), ($urandom_range(0, 15) << 2) | $urandom_range(0, 3), $urandom,
                $urandom_range(0, 1), ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
                $urandom_range(0, 15) == 0);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
